// File: rtl/gf_mul_seq.sv
// gf_mul_seq: iterative multi-lane GF(2^8) multiplier.
// Each byte lane computes a*b mod POLY using MSB-first shift-and-add (Horner).
// One multiplier bit is consumed per cycle, so every product takes eight
// steps. Each byte lane is independent and arithmetic is carry-less, so no
// carry ever passes from one lane to the next.
// Handshakes: valid/ready on the operand side and on the result side.

module gf_mul_seq #(
    parameter int         LANES = 4,
    parameter logic [8:0] POLY  = 9'h11B
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_a,
    input  logic [8*LANES-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_p,
    output logic                 busy
);

    // Reduction constant: the polynomial without its implicit x^8 term.
    localparam logic [7:0] RED_C = POLY[7:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [8*LANES-1:0]   a_q;
    logic [8*LANES-1:0]   b_q;
    logic [8*LANES-1:0]   p_q;
    logic [8*LANES-1:0]   p_d;
    logic [2:0]           cnt_q;
    // Cleared by reset so in_ready stays low for the cycle that follows a
    // reset edge, and is raised by the first edge with rst_n high.
    logic                 ready_q;
    logic                 accept_s;

    // Multiply by x in GF(2^8): shift left, fold the carried-out bit back in.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RED_C : 8'h00);
    endfunction

    // One Horner step per lane: p = x*p + (current multiplier bit ? a : 0).
    always_comb begin
        p_d = '0;
        for (int i = 0; i < LANES; i++) begin
            p_d[8*i +: 8] = xtime(p_q[8*i +: 8])
                          ^ (b_q[8*i + int'(cnt_q)] ? a_q[8*i +: 8] : 8'h00);
        end
    end

    // in_ready never looks at in_valid; in DONE it follows out_ready so a new
    // operation can start on the same edge the result is taken.
    assign in_ready  = ready_q & ((state_q == ST_IDLE) |
                                 ((state_q == ST_DONE) & out_ready));
    assign accept_s  = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign out_p     = p_q;

    // Control FSM and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        p_q     <= '0;
                        cnt_q   <= 3'd7;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q - 3'd1;
                    // The step taken with cnt==0 consumes bit 0 and is final.
                    if (cnt_q == 3'd0) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (accept_s) begin
                            a_q     <= in_a;
                            b_q     <= in_b;
                            p_q     <= '0;
                            cnt_q   <= 3'd7;
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mul_seq.sv
// Self-checking bench for gf_mul_seq: a 4-lane 0x11B instance and a
// 1-lane 0x11D instance, checked against a polynomial-arithmetic model.

module tb_gf_mul_seq;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_a, in_b, out_p;

    logic        alt_in_valid, alt_in_ready, alt_out_valid, alt_out_ready, alt_busy;
    logic [7:0]  alt_a, alt_b, alt_p;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gf_mul_seq #(.LANES(L), .POLY(9'h11B)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .busy(busy)
    );

    gf_mul_seq #(.LANES(1), .POLY(9'h11D)) dut_alt (
        .clk(clk), .rst_n(rst_n),
        .in_valid(alt_in_valid), .in_ready(alt_in_ready),
        .in_a(alt_a), .in_b(alt_b),
        .out_valid(alt_out_valid), .out_ready(alt_out_ready),
        .out_p(alt_p), .busy(alt_busy)
    );

    // Reference: full carry-less product, then long division by the polynomial.
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [8:0] poly);
        logic [14:0] t;
        t = 15'd0;
        for (int i = 0; i < 8; i++)
            if (b[i]) t = t ^ ({7'd0, a} << i);
        for (int k = 14; k >= 8; k--)
            if (t[k]) t = t ^ ({6'd0, poly} << (k - 8));
        return t[7:0];
    endfunction

    function automatic logic [31:0] ref4(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < L; i++)
            r[8*i +: 8] = gf_ref(a[8*i +: 8], b[8*i +: 8], 9'h11B);
        return r;
    endfunction

    // Drive one operation on the 4-lane DUT, return product and edges to out_valid.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] p, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 40);
        p = out_p;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (out_p !== 32'd0) begin n_err++; $display("FAIL rst_out_p: got %h want 0", out_p); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_lane();
        logic [31:0] a, b, p;
        int lat;
        logic [7:0] want0;
        for (int k = 0; k < 2; k++) begin
            a = $urandom; b = $urandom;
            a[7:0] = 8'h57;
            b[7:0] = (k == 0) ? 8'h83 : 8'h13;
            want0  = (k == 0) ? 8'hC1 : 8'hFE;
            do_op(a, b, p, lat);
            n_vec++; if (lat !== 8) begin n_err++; $display("FAIL single_latency: got %0d want 8", lat); end
            n_vec++; if (p[7:0] !== want0) begin n_err++; $display("FAIL single_lane0: got %h want %h", p[7:0], want0); end
            n_vec++; if (p !== ref4(a, b)) begin n_err++; $display("FAIL single_all: got %h want %h", p, ref4(a, b)); end
        end
    endtask

    task automatic test_lanes();
        logic [31:0] p;
        int lat;
        do_op(32'h0053FF80, 32'h9ECAFF02, p, lat);
        n_vec++; if (p !== 32'h0001131B) begin n_err++; $display("FAIL lanes_fixed: got %h want 0001131b", p); end
    endtask

    task automatic test_xtime();
        logic [31:0] a, p;
        int lat;
        for (int base = 0; base < 256; base += 4) begin
            a = {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
            do_op(a, 32'h02020202, p, lat);
            n_vec++; if (p !== ref4(a, 32'h02020202)) begin n_err++; $display("FAIL xtime_%0d: got %h want %h", base, p, ref4(a, 32'h02020202)); end
            if (base == 128) begin
                n_vec++; if (p[7:0] !== 8'h1B) begin n_err++; $display("FAIL xtime_80: got %h want 1b", p[7:0]); end
            end
            if (base == 252) begin
                n_vec++; if (p[31:24] !== 8'hE5) begin n_err++; $display("FAIL xtime_ff: got %h want e5", p[31:24]); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, p;
        int lat;
        for (int k = 0; k < 150; k++) begin
            a = $urandom; b = $urandom;
            if (k % 3 == 0) begin
                b[31:24] = 8'h00; b[23:16] = 8'h01; a[15:8] = 8'h00;
            end
            do_op(a, b, p, lat);
            n_vec++; if (p !== ref4(a, b)) begin n_err++; $display("FAIL random_%0d: a=%h b=%h got %h want %h", k, a, b, p, ref4(a, b)); end
            if (k % 3 == 0) begin
                n_vec++;
                if (p[31:24] !== 8'h00 || p[23:16] !== a[23:16] || p[15:8] !== 8'h00) begin
                    n_err++; $display("FAIL edge_ops: got %h want 00%h00xx", p, a[23:16]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, a2, b2, snap;
        int n, lat;
        a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
        n = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        snap = out_p;
        n_vec++; if (snap !== ref4(a, b)) begin n_err++; $display("FAIL bp_result: got %h want %h", snap, ref4(a, b)); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_p !== snap || in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold_%0d: valid=%b p=%h rdy=%b want 1 %h 0", c, out_valid, out_p, in_ready, snap);
            end
        end
        in_a = a2; in_b = b2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        n_vec++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_restart: busy=%b valid=%b want 1 0", busy, out_valid); end
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_vec++; if (lat !== 8) begin n_err++; $display("FAIL bp_latency: got %0d want 8", lat); end
        n_vec++; if (out_p !== ref4(a2, b2)) begin n_err++; $display("FAIL bp_second: got %h want %h", out_p, ref4(a2, b2)); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 4;
        logic [31:0] oa [N];
        logic [31:0] ob [N];
        int idx, res, cyc, last;
        for (int i = 0; i < N; i++) begin oa[i] = $urandom; ob[i] = $urandom; end
        idx = 0; res = 0; cyc = 0; last = 0;
        while (res < N && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_a = oa[(idx < N) ? idx : N - 1];
            in_b = ob[(idx < N) ? idx : N - 1];
            in_valid = (idx < N);
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                n_vec++; if (out_p !== ref4(oa[res], ob[res])) begin n_err++; $display("FAIL b2b_result_%0d: got %h want %h", res, out_p, ref4(oa[res], ob[res])); end
                if (res > 0) begin
                    n_vec++; if (cyc - last !== 9) begin n_err++; $display("FAIL b2b_spacing_%0d: got %0d want 9", res, cyc - last); end
                end
                last = cyc;
                res++;
            end
            if (in_valid && in_ready) idx++;
        end
        n_vec++; if (res !== N) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", res, N); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b, p;
        int n, lat;
        a = $urandom | 32'h80808080; b = 32'hFFFFFFFF;
        n = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_p !== 32'd0) begin
            n_err++; $display("FAIL midrst: valid=%b busy=%b p=%h want 0 0 0", out_valid, busy, out_p);
        end
        rst_n = 1'b1;
        @(posedge clk);
        a = $urandom; b = $urandom;
        do_op(a, b, p, lat);
        n_vec++; if (p !== ref4(a, b) || lat !== 8) begin n_err++; $display("FAIL midrst_fresh: got %h lat %0d want %h lat 8", p, lat, ref4(a, b)); end
    endtask

    task automatic test_alt_poly();
        int n;
        logic [7:0] want;
        for (int k = 0; k < 4; k++) begin
            alt_a = (k == 0) ? 8'h80 : 8'($urandom);
            alt_b = (k == 0) ? 8'h02 : 8'($urandom);
            want  = gf_ref(alt_a, alt_b, 9'h11D);
            n = 0;
            @(negedge clk);
            alt_in_valid = 1'b1; alt_out_ready = 1'b0;
            while (!alt_in_ready && n < 50) begin @(negedge clk); n++; end
            @(posedge clk);
            #1 alt_in_valid = 1'b0;
            n = 0;
            while (!alt_out_valid && n < 40) begin @(posedge clk); #1; n++; end
            n_vec++; if (alt_p !== want) begin n_err++; $display("FAIL alt_poly_%0d: got %h want %h", k, alt_p, want); end
            if (k == 0) begin
                n_vec++; if (alt_p !== 8'h1D) begin n_err++; $display("FAIL alt_xtime80: got %h want 1d", alt_p); end
            end
            alt_out_ready = 1'b1;
            @(posedge clk);
            #1 alt_out_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = 32'd0; in_b = 32'd0;
        alt_in_valid = 1'b0; alt_out_ready = 1'b0; alt_a = 8'd0; alt_b = 8'd0;
        test_reset();
        test_single_lane();
        test_lanes();
        test_xtime();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_alt_poly();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/gf_mul_seq.md
# gf_mul_seq

Iterative multi-lane GF(2^8) multiplier: each of LANES byte lanes computes a·b modulo the field polynomial POLY with shift-and-add, one multiplier bit per cycle. It generalises the fixed ×2 (xtime) table to arbitrary operands, configurable lane count and configurable reduction polynomial. It sits between the AES round datapath and the MixColumns/InvMixColumns and key-schedule logic, which need ×9/×11/×13/×14 and general products. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- LANES, default 4: number of independent byte lanes; min 1.
- POLY, default 9'h11B: field polynomial. POLY[8] must be 1; the reduction constant is POLY[7:0].

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept operands this cycle.
- in_a  input  8*LANES  multiplicands; lane i is bits [8i+7:8i].
- in_b  input  8*LANES  multipliers; same lane packing.
- out_valid  output  1  out_p holds a finished product.
- out_ready  input  1  consumer accepts out_p.
- out_p  output  8*LANES  products; same lane packing.
- busy  output  1  high in RUN.

## Operation
- Registers:
  - a_r, b_r, p_r: each 8*LANES bits.
  - cnt: 3 bits.
  - state ∈ {IDLE, RUN, DONE}.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? POLY[7:0] : 8'h00), applied per lane. All arithmetic is carry-less (XOR); there are no carries between lanes.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a_r=in_a, b_r=in_b, p_r=0, cnt=7, then go to RUN.
- RUN:
  - Each cycle, per lane: p_r = xtime(p_r) ^ (b_r[cnt] ? a_r : 0). Bits are consumed MSB-first (Horner).
  - cnt decrements each cycle.
  - The step taken with cnt==0 is the last one and moves state to DONE.
  - in_ready=0.
  - Input changes while in RUN are ignored.
- DONE:
  - out_valid=1; out_p=p_r, held stable until out_ready.
  - in_ready=out_ready.
  - out_ready=1 and in_valid=1 (simultaneous): the new operands are accepted in that same cycle (latch a_r, b_r, p_r=0, cnt=7) → RUN.
  - out_ready=1 and in_valid=0 → IDLE.
  - out_ready=0 → stay in DONE.
- out_p is driven from p_r at all times. It is only meaningful while out_valid=1.
- Any value of b gives exactly 8 steps. There is no early termination.
- Operand edge cases:
  - b=0 gives 0.
  - b=1 gives a.
  - a=0 gives 0.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, cnt=0, and a_r, b_r, p_r all zero.
  - Outputs: out_valid=0, busy=0, out_p=0, in_ready=0 during the reset cycle.
  - in_ready becomes 1 in the first cycle after rst_n returns high.
- Reset mid-RUN or in DONE: the operation is discarded with no output, and the reset values above apply on the next edge.
- Timing of one operation:
  - Operands accepted at edge k.
  - busy=1 for cycles k+1..k+8.
  - out_valid=1 from the cycle after edge k+8 (8-cycle latency, accept to result).
- Back-to-back with out_ready held high: one result every 9 cycles, with no IDLE bubble between operations.
- Backpressure: out_valid and out_p stay constant while out_ready=0, for any number of cycles.
- Handshake contract: in_ready does not depend on in_valid. out_valid does not depend on out_ready.

## Test plan
- Single lane (LANES=1): a=0x57, b=0x83 → out_p=0xC1, out_valid exactly 8 edges after accept. Also a=0x57, b=0x13 → 0xFE.
- LANES=4, lanes {a,b} = {0x80,0x02}, {0xFF,0xFF}, {0x53,0xCA}, {0x00,0x9E} → out_p lanes 0x1B, 0x13, 0x01, 0x00 respectively (no cross-lane leakage).
- Exhaustive self-check on lane 0: all 65536 (a,b) pairs compared against a software GF model. The subset b=0x02 must match the xtime table (e.g. 0x80→0x1B, 0xFF→0xE5).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_p stable, in_ready=0. Then out_ready=1 with in_valid=1 → new operands accepted the same cycle, and the next result arrives 8 cycles later.
- Reset mid-op: drive rst_n=0 at cycle 4 of RUN → next cycle out_valid=0, busy=0, out_p=0. A fresh operation after reset produces the correct product.
- Alternate polynomial POLY=9'h11D: a=0x80, b=0x02 → 0x1D.
